// File: rtl/mux_sel_seq.sv
// Select sequencer for the downstream 3:1 channel mux: auto stepping with a
// programmable dwell, or manual step/load control, with change/wrap strobes.
module mux_sel_seq #(
  parameter int NB_COUNT = 8
) (
  input  logic                e_clock,
  input  logic                e_reset,
  input  logic                e_enable,
  input  logic                e_mode,
  input  logic [NB_COUNT-1:0] e_dwell,
  input  logic                e_step,
  input  logic                e_load,
  input  logic [1:0]          e_manual_sel,
  output logic [1:0]          s_muxsel,
  output logic                s_sel_change,
  output logic                s_cycle_done,
  output logic [1:0]          s_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_AUTO   = 2'd1,
    ST_MANUAL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [1:0]          sel_q, sel_d;
  logic                step_prev_q, step_prev_d;
  logic                chg_q, chg_d;
  logic                done_q, done_d;

  state_t              target;
  logic                adv;
  logic [1:0]          next_sel;

  always_ff @(posedge e_clock) begin
    if (e_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sel_q       <= 2'b00;
      step_prev_q <= 1'b0;
      chg_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      step_prev_q <= step_prev_d;
      chg_q       <= chg_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    step_prev_d = e_step;
    done_d      = 1'b0;
    adv         = 1'b0;
    target      = e_mode ? ST_MANUAL : ST_AUTO;
    next_sel    = (sel_q == 2'b10) ? 2'b00 : sel_q + 2'd1;

    if (!e_enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q != target) begin
      // Entering from IDLE or switching modes: select is held, dwell restarts.
      state_d = target;
      cnt_d   = '0;
    end else if (state_q == ST_AUTO) begin
      // A counter beyond a freshly lowered dwell simply wraps through all-ones.
      if (cnt_q == e_dwell) begin
        cnt_d = '0;
        adv   = 1'b1;
      end else begin
        cnt_d = cnt_q + NB_COUNT'(1);
      end
    end else begin
      cnt_d = '0;
      if (e_load) begin
        if (e_manual_sel != 2'b11) sel_d = e_manual_sel;
      end else if (e_step && !step_prev_q) begin
        adv = 1'b1;
      end
    end

    if (adv) begin
      sel_d  = next_sel;
      done_d = (sel_q == 2'b10);
    end
    chg_d = (sel_d != sel_q);
  end

  assign s_muxsel     = sel_q;
  assign s_sel_change = chg_q;
  assign s_cycle_done = done_q;
  assign s_state      = state_q;

endmodule

// File: tb/tb_mux_sel_seq.sv
// Bench for mux_sel_seq: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural model.
module tb_mux_sel_seq;

  logic       e_clock = 1'b0;
  logic       e_reset = 1'b1;
  logic       e_enable = 1'b0;
  logic       e_mode = 1'b0;
  logic [7:0] e_dwell = 8'd0;
  logic       e_step = 1'b0;
  logic       e_load = 1'b0;
  logic [1:0] e_manual_sel = 2'b00;
  logic [1:0] s_muxsel;
  logic       s_sel_change;
  logic       s_cycle_done;
  logic [1:0] s_state;

  int errors = 0;
  int checks = 0;

  mux_sel_seq #(.NB_COUNT(8)) dut (
    .e_clock      (e_clock),
    .e_reset      (e_reset),
    .e_enable     (e_enable),
    .e_mode       (e_mode),
    .e_dwell      (e_dwell),
    .e_step       (e_step),
    .e_load       (e_load),
    .e_manual_sel (e_manual_sel),
    .s_muxsel     (s_muxsel),
    .s_sel_change (s_sel_change),
    .s_cycle_done (s_cycle_done),
    .s_state      (s_state)
  );

  // clock / reset
  always #5 e_clock = ~e_clock;

  // Behavioural model: mode 0=idle 1=auto 2=manual, channel as an integer 0..2.
  int m_mode = 0, m_cnt = 0, m_sel = 0, m_chg = 0, m_done = 0, m_prev_step = 0;
  bit m_valid = 1'b0;

  task automatic model_advance(inout int nsel, inout int wrap);
    wrap = (m_sel == 2) ? 1 : 0;
    nsel = (m_sel + 1) % 3;
  endtask

  always @(posedge e_clock) begin
    int nsel, wrap, want;
    if (e_reset) begin
      m_mode = 0; m_cnt = 0; m_sel = 0; m_chg = 0; m_done = 0; m_prev_step = 0;
      m_valid = 1'b1;
    end else begin
      nsel = m_sel;
      wrap = 0;
      want = e_mode ? 2 : 1;
      if (!e_enable) begin
        m_mode = 0; m_cnt = 0;
      end else if (m_mode != want) begin
        m_mode = want; m_cnt = 0;
      end else if (m_mode == 1) begin
        if (m_cnt == int'(e_dwell)) begin
          m_cnt = 0;
          model_advance(nsel, wrap);
        end else begin
          m_cnt = (m_cnt + 1) % 256;
        end
      end else begin
        if (e_load) begin
          if (e_manual_sel != 2'b11) nsel = int'(e_manual_sel);
        end else if (e_step && m_prev_step == 0) begin
          model_advance(nsel, wrap);
        end
      end
      m_chg = (nsel != m_sel) ? 1 : 0;
      m_done = wrap;
      m_sel = nsel;
      m_prev_step = e_step ? 1 : 0;
    end
  end

  // scoreboard helper
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // compare process, away from the active edge
  always @(negedge e_clock) begin
    if (m_valid) begin
      chk("model_muxsel", int'(s_muxsel), m_sel);
      chk("model_sel_change", int'(s_sel_change), m_chg);
      chk("model_cycle_done", int'(s_cycle_done), m_done);
      chk("model_state", int'(s_state), m_mode);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge e_clock);
  endtask

  task automatic do_reset();
    e_reset = 1'b1; e_enable = 1'b0; e_step = 1'b0; e_load = 1'b0;
    tick(2);
    e_reset = 1'b0;
  endtask

  int lit_sel[10]  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 0};
  int lit_chg[10]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int lit_done[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    do_reset();
    tick(1);
    chk("reset_muxsel", int'(s_muxsel), 0);
    chk("reset_state", int'(s_state), 0);
    chk("reset_strobes", int'(s_sel_change) + int'(s_cycle_done), 0);

    // auto, dwell 2
    e_mode = 1'b0; e_dwell = 8'd2; e_enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("dwell2_sel", int'(s_muxsel), lit_sel[i]);
      chk("dwell2_chg", int'(s_sel_change), lit_chg[i]);
      chk("dwell2_done", int'(s_cycle_done), lit_done[i]);
    end

    // auto, dwell 0
    do_reset();
    e_mode = 1'b0; e_dwell = 8'd0; e_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      chk("dwell0_sel", int'(s_muxsel), i % 3);
      chk("dwell0_chg", int'(s_sel_change), (i > 0) ? 1 : 0);
      chk("dwell0_done", int'(s_cycle_done), (i > 0 && i % 3 == 0) ? 1 : 0);
    end

    // manual: held step gives one advance, then three toggles
    do_reset();
    e_mode = 1'b1; e_enable = 1'b1;
    tick(2);
    e_step = 1'b1;
    tick(5);
    e_step = 1'b0;
    tick(1);
    chk("manual_held_step", int'(s_muxsel), 1);
    for (int i = 0; i < 3; i++) begin
      e_step = 1'b1; tick(1);
      e_step = 1'b0; tick(1);
    end
    chk("manual_toggle_sel", int'(s_muxsel), 1);

    // load beats a simultaneous step edge; invalid and same-value loads are silent
    e_load = 1'b1; e_manual_sel = 2'b10; e_step = 1'b1;
    tick(1);
    chk("load_sel", int'(s_muxsel), 2);
    chk("load_chg", int'(s_sel_change), 1);
    e_step = 1'b0; e_manual_sel = 2'b11;
    tick(1);
    chk("load11_sel", int'(s_muxsel), 2);
    chk("load11_chg", int'(s_sel_change), 0);
    e_manual_sel = 2'b10;
    tick(1);
    chk("load_same_chg", int'(s_sel_change), 0);
    e_manual_sel = 2'b00;
    tick(1);
    chk("load_to_00_done", int'(s_cycle_done), 0);
    e_load = 1'b0;

    // dwell lowered below the running count: wrap through all-ones
    do_reset();
    e_mode = 1'b0; e_dwell = 8'd9; e_enable = 1'b1;
    tick(7);
    e_dwell = 8'd3;
    tick(253);
    chk("wrap_still_ch0", int'(s_muxsel), 0);
    tick(1);
    chk("wrap_advance", int'(s_muxsel), 1);
    chk("wrap_advance_chg", int'(s_sel_change), 1);

    // reset mid-auto while on channel 2
    do_reset();
    e_mode = 1'b0; e_dwell = 8'd0; e_enable = 1'b1;
    tick(3);
    chk("pre_reset_sel", int'(s_muxsel), 2);
    e_reset = 1'b1;
    tick(1);
    e_reset = 1'b0;
    chk("midreset_sel", int'(s_muxsel), 0);
    chk("midreset_state", int'(s_state), 0);
    chk("midreset_strobes", int'(s_sel_change) + int'(s_cycle_done), 0);

    // disable mid-dwell freezes the select
    do_reset();
    e_mode = 1'b0; e_dwell = 8'd5; e_enable = 1'b1;
    tick(8);
    e_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("disable_frozen", int'(s_muxsel), 1);
      chk("disable_no_strobe", int'(s_sel_change), 0);
    end

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      e_reset      = ($urandom_range(0, 199) == 0);
      e_enable     = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 39) == 0) e_mode = ~e_mode;
      if ($urandom_range(0, 29) == 0) e_dwell = 8'($urandom_range(0, 4));
      e_step       = 1'($urandom_range(0, 1));
      e_load       = ($urandom_range(0, 7) == 0);
      e_manual_sel = 2'($urandom_range(0, 3));
      tick(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
